// File: rtl/ospfb_impulse_src_cap.sv
// Impulse source and capture harness for OSPFB bring-up.
//
// An impulse generator fills a first-word-fall-through FIFO with a periodic
// stream (one non-zero real sample per FFT_LEN-sample frame), presented on an
// AXI-Stream master. A capture engine stores an AXI-Stream slave input into a
// SAMP-word RAM, then raises vip_full and stops accepting data.
//
// Ports
//   clk, rst          sole clock; asynchronous active-high reset
//   en                generator enable
//   m_axis_*          source stream {im, re} to the OSPFB
//   s_axis_*          OSPFB output stream into the capture RAM
//   almost_empty, almost_full, prog_empty, prog_full
//                     registered FIFO occupancy flags
//   rd_count, wr_count
//                     FIFO occupancy, saturated at FIFO_DEPTH-1
//   vip_full          capture RAM full (sticky until rst)
//   ram_raddr/rdata   capture RAM read port, 1-cycle latency
module ospfb_impulse_src_cap #(
  parameter int unsigned WIDTH             = 16,
  parameter int unsigned FFT_LEN           = 64,
  parameter int unsigned IMPULSE_PHASE     = 49,
  parameter int          PULSE_VAL         = 4096,
  parameter int unsigned SAMP              = 2048,
  parameter int unsigned FIFO_DEPTH        = 32,
  parameter int unsigned PROG_EMPTY_THRESH = 16,
  parameter int unsigned PROG_FULL_THRESH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic [2*WIDTH-1:0]            m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [2*WIDTH-1:0]            s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic                          prog_empty,
  output logic                          prog_full,
  output logic [$clog2(FIFO_DEPTH)-1:0] rd_count,
  output logic [$clog2(FIFO_DEPTH)-1:0] wr_count,
  output logic                          vip_full,
  input  logic [$clog2(SAMP)-1:0]       ram_raddr,
  output logic [2*WIDTH-1:0]            ram_rdata
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int unsigned RW = $clog2(SAMP);

  localparam logic [WIDTH-1:0] PulseRe    = WIDTH'(PULSE_VAL);
  localparam logic [IW-1:0]    PhaseIdx   = IW'(IMPULSE_PHASE);
  localparam logic [IW-1:0]    LastIdx    = IW'(FFT_LEN - 1);
  localparam logic [AW:0]      Depth      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]      DepthM1    = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0]      PeThresh   = (AW + 1)'(PROG_EMPTY_THRESH);
  localparam logic [AW:0]      PfThresh   = (AW + 1)'(PROG_FULL_THRESH);
  localparam logic [RW-1:0]    LastAddr   = RW'(SAMP - 1);

  // ---------------------------------------------------------------------------
  // Impulse generator
  // ---------------------------------------------------------------------------
  logic [IW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sample_re;
  logic [DW-1:0]  sample;
  logic           push, pop, fifo_full;

  assign push      = en & ~fifo_full;
  assign sample_re = (idx_q == PhaseIdx) ? PulseRe : '0;
  assign sample    = {{WIDTH{1'b0}}, sample_re};

  always_comb begin
    idx_d = idx_q;
    if (push) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] count_sat;

  assign fifo_full     = (count_q == Depth);
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem[rd_ptr_q];
  assign pop           = m_axis_tvalid & m_axis_tready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flags and counts track the post-edge occupancy, so derive them from count_d.
  assign count_sat = (count_d > DepthM1) ? DepthM1[AW-1:0] : count_d[AW-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      almost_empty <= 1'b1;
      prog_empty   <= 1'b1;
      almost_full  <= 1'b0;
      prog_full    <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      almost_empty <= (count_d <= (AW + 1)'(1));
      prog_empty   <= (count_d <= PeThresh);
      almost_full  <= (count_d >= DepthM1);
      prog_full    <= (count_d >= PfThresh);
      rd_count     <= count_sat;
      wr_count     <= count_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture engine
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram [SAMP];
  logic [RW-1:0] wptr_q;
  logic          vip_full_q;
  logic          cap_en_q;
  logic          beat;

  // cap_en_q keeps tready low during reset and lifts it one edge after release.
  assign s_axis_tready = cap_en_q & ~vip_full_q;
  assign vip_full      = vip_full_q;
  assign beat          = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_en_q   <= 1'b0;
      vip_full_q <= 1'b0;
      wptr_q     <= '0;
    end else begin
      cap_en_q <= 1'b1;
      if (beat) begin
        wptr_q <= wptr_q + 1'b1;
        if (wptr_q == LastAddr) begin
          vip_full_q <= 1'b1;
        end
      end
    end
  end

  // RAM is deliberately outside reset so captured data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (beat) begin
      ram[wptr_q] <= s_axis_tdata;
    end
    ram_rdata <= ram[ram_raddr];
  end

endmodule

// File: tb/tb_ospfb_impulse_src_cap.sv
module tb_ospfb_impulse_src_cap;

  localparam int W  = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          almost_empty, almost_full, prog_empty, prog_full;
  logic [4:0]    rd_count, wr_count;
  logic          vip_full;
  logic [10:0]   ram_raddr;
  logic [DW-1:0] ram_rdata;

  // Loopback select: source stream feeds capture directly when set.
  logic          loop;
  logic          drv_m_tready;
  logic [DW-1:0] drv_s_tdata;
  logic          drv_s_tvalid;

  assign m_axis_tready = loop ? s_axis_tready : drv_m_tready;
  assign s_axis_tdata  = loop ? m_axis_tdata  : drv_s_tdata;
  assign s_axis_tvalid = loop ? m_axis_tvalid : drv_s_tvalid;

  int tests = 0;
  int fails = 0;
  int k     = 0;    // stream index of the next expected source beat
  int last_imp = -1;

  always #5 clk = ~clk;

  ospfb_impulse_src_cap dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .almost_empty  (almost_empty),
    .almost_full   (almost_full),
    .prog_empty    (prog_empty),
    .prog_full     (prog_full),
    .rd_count      (rd_count),
    .wr_count      (wr_count),
    .vip_full      (vip_full),
    .ram_raddr     (ram_raddr),
    .ram_rdata     (ram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pattern(input int idx);
    return (idx % 64 == 49) ? 32'h0000_1000 : 32'h0;
  endfunction

  task automatic flags(input string tag, input logic ae, input logic pe, input logic af,
                       input logic pf, input logic [4:0] cnt);
    chk({tag, ".almost_empty"}, almost_empty, ae);
    chk({tag, ".prog_empty"},   prog_empty,   pe);
    chk({tag, ".almost_full"},  almost_full,  af);
    chk({tag, ".prog_full"},    prog_full,    pf);
    chk({tag, ".rd_count"},     rd_count,     cnt);
    chk({tag, ".wr_count"},     wr_count,     cnt);
  endtask

  // Consume the source stream for n cycles, checking every popped beat.
  task automatic run_stream(input int n, input bit toggle, output int imps);
    imps = 0;
    for (int c = 0; c < n; c++) begin
      drv_m_tready = toggle ? c[0] : 1'b1;
      if (m_axis_tvalid && drv_m_tready) begin
        chk("stream.data", m_axis_tdata, pattern(k));
        if (m_axis_tdata[15:0] != 16'h0) begin
          imps++;
          if (last_imp >= 0) chk("stream.spacing", k - last_imp, 64);
          last_imp = k;
        end
        k++;
      end
      tick();
    end
  endtask

  // Drive n capture beats with data base+i, each bounded by a ready timeout.
  task automatic cap_beats(input int n, input logic [DW-1:0] base);
    int w;
    for (int i = 0; i < n; i++) begin
      drv_s_tdata  = base + DW'(i);
      drv_s_tvalid = 1'b1;
      w = 0;
      while (!s_axis_tready && w < 10) begin
        tick();
        w++;
      end
      if (w >= 10) chk("cap.ready_timeout", 1'b0, 1'b1);
      tick();
    end
    drv_s_tvalid = 1'b0;
  endtask

  task automatic ram_rd(input int a, input logic [DW-1:0] exp_v);
    ram_raddr = 11'(a);
    tick();
    chk($sformatf("ram[%0d]", a), ram_rdata, exp_v);
  endtask

  initial begin
    int imps;
    int acc;
    int cyc;
    rst = 1'b1; en = 1'b0; loop = 1'b0;
    drv_m_tready = 1'b0; drv_s_tdata = '0; drv_s_tvalid = 1'b0; ram_raddr = '0;

    // Reset state
    tick(); tick();
    chk("rst.tvalid", m_axis_tvalid, 1'b0);
    chk("rst.s_tready", s_axis_tready, 1'b0);
    chk("rst.vip_full", vip_full, 1'b0);
    flags("rst", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);

    rst = 1'b0;
    tick();
    chk("rel.s_tready", s_axis_tready, 1'b1);

    // Fill with no consumer
    en = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick();
      case (i)
        1:  flags("fill1",  1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        2:  flags("fill2",  1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
        15: flags("fill15", 1'b0, 1'b1, 1'b0, 1'b0, 5'd15);
        16: flags("fill16", 1'b0, 1'b1, 1'b0, 1'b1, 5'd16);
        17: flags("fill17", 1'b0, 1'b0, 1'b0, 1'b1, 5'd17);
        30: flags("fill30", 1'b0, 1'b0, 1'b0, 1'b1, 5'd30);
        31: flags("fill31", 1'b0, 1'b0, 1'b1, 1'b1, 5'd31);
        32: flags("fill32", 1'b0, 1'b0, 1'b1, 1'b1, 5'd31);
        34: flags("fill34", 1'b0, 1'b0, 1'b1, 1'b1, 5'd31);
        default: ;
      endcase
    end

    // Drain with generator disabled
    en = 1'b0;
    run_stream(32, 1'b0, imps);
    chk("drain.beats", k, 32);
    chk("drain.tvalid", m_axis_tvalid, 1'b0);
    flags("drain", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);

    // Steady streaming continues from the held index (impulses at 49,113,177)
    en = 1'b1;
    run_stream(200, 1'b0, imps);
    chk("stream.impulses", imps, 3);

    // Toggling ready: FIFO backs up, generator stalls, nothing lost
    run_stream(400, 1'b1, imps);
    chk("toggle.beats", k, 431);
    chk("toggle.impulses", imps, 3);

    // Full capture through loopback, from a fresh reset
    rst = 1'b1;
    #1;
    chk("rst2.tvalid", m_axis_tvalid, 1'b0);
    tick();
    rst = 1'b0; loop = 1'b1;
    acc = 0; cyc = 0;
    while (!vip_full && cyc < 3000) begin
      if (s_axis_tvalid && s_axis_tready) acc++;
      tick();
      cyc++;
    end
    chk("cap.vip_full", vip_full, 1'b1);
    chk("cap.beats", acc, 2048);
    chk("cap.s_tready", s_axis_tready, 1'b0);
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (s_axis_tvalid && s_axis_tready) acc++;
      tick();
    end
    chk("cap.extra_beats", acc, 0);
    chk("cap.tvalid_pending", m_axis_tvalid, 1'b1);
    loop = 1'b0;
    for (int a = 0; a < 2048; a++) ram_rd(a, pattern(a));

    // Reset clears the sticky full flag and the FIFO; RAM keeps its data
    rst = 1'b1;
    #1;
    chk("rst3.vip_full", vip_full, 1'b0);
    chk("rst3.tvalid", m_axis_tvalid, 1'b0);
    chk("rst3.s_tready", s_axis_tready, 1'b0);
    tick();
    rst = 1'b0; en = 1'b1; drv_m_tready = 1'b0;
    cap_beats(10, 32'hA000_0000);
    tick(); tick();
    chk("mid.tvalid_before", m_axis_tvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid.vip_full", vip_full, 1'b0);
    chk("mid.tvalid", m_axis_tvalid, 1'b0);
    chk("mid.s_tready", s_axis_tready, 1'b0);
    flags("mid", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    rst = 1'b0; en = 1'b0;
    cap_beats(3, 32'hB000_0000);
    tick();
    ram_rd(0, 32'hB000_0000);
    ram_rd(1, 32'hB000_0001);
    ram_rd(2, 32'hB000_0002);
    ram_rd(3, 32'hA000_0003);
    ram_rd(9, 32'hA000_0009);
    ram_rd(10, 32'h0);
    ram_rd(49, 32'h0000_1000);
    ram_rd(2033, 32'h0000_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ospfb_impulse_src_cap.md
OSPFB_IMPULSE_SRC_CAP -- requirements
Module: ospfb_impulse_src_cap

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per real/imag component.
REQ-002 SHALL have parameter FFT_LEN, default 64, meaning samples per impulse frame.
REQ-003 SHALL have parameter IMPULSE_PHASE, default 49, meaning in-frame sample index of the impulse, range 0..FFT_LEN-1.
REQ-004 SHALL have parameter PULSE_VAL, default 4096, meaning impulse real value as a signed WIDTH integer.
REQ-005 SHALL have parameter SAMP, default 2048, meaning capture RAM depth in words.
REQ-006 SHALL have parameter FIFO_DEPTH, default 32, meaning FIFO entries as a power of two.
REQ-007 SHALL have parameters PROG_EMPTY_THRESH and PROG_FULL_THRESH, each default 16, meaning programmable occupancy thresholds.
REQ-008 SHALL have clk  in  1  sole clock; all logic on its rising edge.
REQ-009 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-010 SHALL have en  in  1  source enable.
REQ-011 SHALL have m_axis_tdata/tvalid/tready  out/out/in  2*WIDTH/1/1  source stream to the OSPFB, packed {im, re}.
REQ-012 SHALL have s_axis_tdata/tvalid/tready  in/in/out  2*WIDTH/1/1  OSPFB output stream to capture.
REQ-013 SHALL have almost_empty, almost_full, prog_empty, prog_full  out  1 each  FIFO flags.
REQ-014 SHALL have rd_count, wr_count  out  $clog2(FIFO_DEPTH)  FIFO occupancy.
REQ-015 SHALL have vip_full  out  1  capture complete.
REQ-016 SHALL have ram_raddr/ram_rdata  in/out  $clog2(SAMP)/2*WIDTH  capture RAM read port, 1-cycle read latency.

Function
REQ-017 Impulse generator SHALL keep sample index idx, 0..FFT_LEN-1, that advances and wraps to 0 after FFT_LEN-1 on each FIFO write.
REQ-018 Generator SHALL write one sample per cycle while en=1 and FIFO not full; it SHALL stall with idx held otherwise.
REQ-019 Sample SHALL be re=PULSE_VAL when idx==IMPULSE_PHASE, else re=0; im SHALL always be 0.
REQ-020 FIFO SHALL be synchronous and first-word fall-through, FIFO_DEPTH entries.
REQ-021 m_axis_tvalid SHALL equal FIFO not-empty; m_axis_tdata SHALL equal the head entry; a pop SHALL occur on tvalid&tready.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 A push when full SHALL be impossible; a pop when empty SHALL be impossible.
REQ-024 rd_count and wr_count SHALL both equal occupancy, saturated at FIFO_DEPTH-1.
REQ-025 almost_empty SHALL be occupancy<=1; almost_full SHALL be occupancy>=FIFO_DEPTH-1.
REQ-026 prog_empty SHALL be occupancy<=PROG_EMPTY_THRESH; prog_full SHALL be occupancy>=PROG_FULL_THRESH.
REQ-027 All flags SHALL be registered and SHALL reflect occupancy after the current edge.
REQ-028 Capture s_axis_tready SHALL be ~vip_full.
REQ-029 Each accepted beat (tvalid&tready) SHALL be written to ram[wptr], after which wptr increments.
REQ-030 On the SAMP-th write, vip_full SHALL set the next cycle and stay sticky until rst; no further writes SHALL occur.
REQ-031 ram_rdata SHALL equal ram[ram_raddr] one cycle after ram_raddr is presented, independent of capture state.

Reset
REQ-032 While rst=1: idx=0, FIFO empty, m_axis_tvalid=0, wptr=0, vip_full=0, s_axis_tready=0.
REQ-033 While rst=1: almost_empty=1, prog_empty=1, almost_full=0, prog_full=0, counts=0.
REQ-034 s_axis_tready SHALL rise the first cycle after rst deasserts.
REQ-035 RAM contents SHALL not be cleared by reset.
REQ-036 Reset asserted mid-operation SHALL abort immediately and discard FIFO contents.

Verification
REQ-037 Scenario: rst released, en=1, m_axis_tready=1 -> m_axis stream re equals 4096 at indices 49, 113, 177, ... and 0 elsewhere; im=0 throughout.
REQ-038 Scenario: en=1, m_axis_tready=0 -> after 32 writes FIFO is full, almost_full=1, prog_full=1, counts=31, and idx holds at 32.
REQ-039 Scenario: from full, tready=1 with en=0 -> 32 beats drain in order, then tvalid=0, almost_empty=1, prog_empty=1.
REQ-040 Scenario: loop m_axis to s_axis for 2048 beats -> vip_full=1 and ram[k]=4096 iff k mod 64==49, else 0; beat 2049 is not accepted.
REQ-041 Scenario: rst pulsed at mid-capture -> vip_full=0, tvalid=0, and the next capture restarts at address 0.
REQ-042 Scenario: toggle m_axis_tready every cycle -> no sample lost or duplicated, and the impulse spacing stays exactly 64 samples.
